ctrl_burst_cas: RTL
===================

# ctrl_burst_cas

Column-command (CAS) scheduler for the DDR4 controller, directly downstream of the activate controller. It accepts "row open" notifications (`act_rdy` after a fresh ACTIVATE, `no_act_rdy` on a row hit), enforces tRCD and CAS-to-CAS spacing, and issues a one-cycle `cas_rdy` strobe with the request type. It then times read/write data-phase start strobes for the data path and reports `cas_idle` back to the activate controller's precharge logic.

## Interface
Parameters:
- `tRCD`, 16: cycles from ACTIVATE strobe to earliest CAS.
- `tCCD`, 4: minimum cycles between consecutive CAS strobes.
- `CL`, 16: CAS strobe to `rd_data_start`.
- `CWL`, 12: CAS strobe to `wr_data_start`.
- `tWTR`, 4: extra write-to-read gap (macro only).
- `tRTW`, 8: extra read-to-write gap (macro only).

Ports:
- `CK_t` input 1: controller clock; all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `act_rdy` input 1: one-cycle pulse, ACTIVATE issued this cycle.
- `no_act_rdy` input 1: one-cycle pulse, row hit, no ACTIVATE needed.
- `act_rw` input 3: request type (`RD_R`/`WR_R` from ddr_pkg), valid with either pulse.
- `cas_rdy` output 1: one-cycle CAS command strobe.
- `cas_req` output 3: type of the current/last CAS, held until the next CAS.
- `cas_idle` output 1: no CAS pending, none in flight, data phase complete.
- `rd_data_start` output 1: one-cycle pulse, read data window opens.
- `wr_data_start` output 1: one-cycle pulse, write data window opens.
- `cas_ovf` output 1: sticky error, request dropped because the buffer was full.

## Operation
- Reset values: `cas_rdy`=0, `cas_req`=0, `cas_idle`=1, `rd_data_start`=0, `wr_data_start`=0, `cas_ovf`=0. FSM goes to CAS_IDLE, pending entry is cleared, counters are zeroed. Reset mid-operation aborts everything without emitting further strobes.
- One-entry pending buffer `{type, needs_trcd}`, loaded on `act_rdy` (needs_trcd=1) or `no_act_rdy` (needs_trcd=0).
- If both pulses arrive in the same cycle, `act_rdy` wins and `no_act_rdy` is dropped with `cas_ovf` set.
- A pulse arriving while the entry is occupied and not being consumed that cycle is dropped and sets `cas_ovf`. `cas_ovf` clears only on reset.
- FSM states:
  - CAS_IDLE: goes to CAS_WAIT_ACT when the buffer is valid.
  - CAS_WAIT_ACT: `act_cnt` counts from load. Exit when needs_trcd=0, or when `act_cnt` ≥ tRCD−1.
  - CAS_WAIT_GAP: wait until `gap_cnt` (cycles since last CAS, 8-bit, saturating at 255) ≥ required gap.
  - CAS_CMD: assert `cas_rdy` for one cycle, latch `cas_req`, free the buffer, zero `gap_cnt`, arm the data timer, then return to CAS_IDLE.
- Required gap is tCCD. It is enlarged by turnaround only under the macro.
- Data timer is a per-CAS countdown, loaded with CL or CWL. Up to two launches may be in flight; if a third launch is needed, it stalls CAS_CMD.
- `cas_idle` = CAS_IDLE AND buffer empty AND no data timer running.

## Timing
- `act_rdy` at cycle T with idle history: `cas_rdy` at T+tRCD.
- `no_act_rdy` at T: `cas_rdy` at the later of T+1 and lastCAS+gap.
- `cas_rdy` at C: `rd_data_start` at C+CL for reads, `wr_data_start` at C+CWL for writes.
- `cas_idle` drops the cycle after a pulse is accepted and rises the cycle after the last data-start strobe.
- A buffer freed in CAS_CMD may accept a new pulse in the same cycle with no overflow.

## Configuration
- `CAS_TURNAROUND_EN` defined:
  - WR then RD: gap = max(tCCD, CWL+4+tWTR).
  - RD then WR: gap = max(tCCD, tRTW).
  - Same-type back-to-back: gap = tCCD.
- Undefined: gap is always tCCD, and the `tWTR`/`tRTW` parameters are unused.

## Test plan
- `act_rdy`+`RD_R` at cycle 10: `cas_rdy` at 26, `cas_req`=`RD_R`, `rd_data_start` at 42, `cas_idle` high at 43.
- `no_act_rdy`+`WR_R` at 5 after long idle: `cas_rdy` at 6, `wr_data_start` at 18.
- Two `no_act_rdy` RD hits at cycles 5 and 6: CAS strobes at 6 and 10 (tCCD=4), two `rd_data_start` pulses at 22 and 26.
- `CAS_TURNAROUND_EN`: WR CAS at 6, then RD hit at 7: second CAS at 26 (gap 20). Without the macro: second CAS at 10.
- `act_rdy` and `no_act_rdy` together, or a third pulse while the buffer is full: `cas_ovf`=1, exactly one CAS issued for the kept request.
- `reset_n` low at cycle 15 with a CAS pending: all outputs at reset values within the same cycle, no `cas_rdy` afterwards, `cas_idle`=1.

Source files
------------

// File: rtl/ctrl_burst_cas.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_burst_cas
// Description : Column-command (CAS) scheduler for the DDR4 controller.
//               It sits behind the activate controller and takes "row open"
//               notifications: act_rdy after a fresh ACTIVATE, no_act_rdy on
//               a row hit. It enforces tRCD and CAS-to-CAS spacing, issues a
//               one-cycle cas_rdy strobe with the request type, times the
//               read/write data-phase start strobes, and reports cas_idle
//               back to the precharge logic.
//
// Parameters  : tRCD  ACTIVATE strobe to earliest CAS (cycles)
//               tCCD  minimum CAS-to-CAS spacing (cycles)
//               CL    CAS to rd_data_start (cycles, >= 1)
//               CWL   CAS to wr_data_start (cycles, >= 1)
//               tWTR  extra write-to-read gap (turnaround build only)
//               tRTW  extra read-to-write gap (turnaround build only)
//
// Macro       : CAS_TURNAROUND_EN - when defined, the CAS gap is widened on a
//               WR->RD or RD->WR change of direction. When undefined the gap
//               is always tCCD and tWTR/tRTW have no effect.
//
// Ports       : CK_t          in   controller clock, rising edge
//               reset_n       in   asynchronous active-low reset
//               act_rdy       in   pulse: ACTIVATE issued this cycle
//               no_act_rdy    in   pulse: row hit, no ACTIVATE needed
//               act_rw[2:0]   in   request type, valid with either pulse
//               cas_rdy       out  one-cycle CAS command strobe
//               cas_req[2:0]  out  type of current/last CAS
//               cas_idle      out  nothing pending, in flight or in data phase
//               rd_data_start out  pulse: read data window opens
//               wr_data_start out  pulse: write data window opens
//               cas_ovf       out  sticky: a request was dropped
//
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_burst_cas #(
    parameter int tRCD = 16,
    parameter int tCCD = 4,
    parameter int CL   = 16,
    parameter int CWL  = 12,
    parameter int tWTR = 4,
    parameter int tRTW = 8
) (
    input  logic       CK_t,
    input  logic       reset_n,
    input  logic       act_rdy,
    input  logic       no_act_rdy,
    input  logic [2:0] act_rw,
    output logic       cas_rdy,
    output logic [2:0] cas_req,
    output logic       cas_idle,
    output logic       rd_data_start,
    output logic       wr_data_start,
    output logic       cas_ovf
);

    // Request type codes, matching the ddr_pkg encoding.
    localparam logic [2:0] c_RD_R = 3'd1;
    localparam logic [2:0] c_WR_R = 3'd2;

`ifdef CAS_TURNAROUND_EN
    localparam bit c_TA_EN = 1'b1;
`else
    localparam bit c_TA_EN = 1'b0;
`endif

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Gap thresholds are stored as (gap - 1): the FSM decides one cycle
    // before the strobe, when gap_cnt is one short of the real spacing.
    localparam logic [7:0] c_TCCD_M1  = 8'(tCCD - 1);
    localparam logic [7:0] c_WR2RD_M1 = 8'(max2(tCCD, CWL + 4 + tWTR) - 1);
    localparam logic [7:0] c_RD2WR_M1 = 8'(max2(tCCD, tRTW) - 1);
    localparam logic [7:0] c_TRCD_M1  = 8'(tRCD - 1);
    localparam logic [7:0] c_CL       = 8'(CL);
    localparam logic [7:0] c_CWL      = 8'(CWL);

    typedef enum logic [1:0] {
        CAS_IDLE     = 2'd0,
        CAS_WAIT_ACT = 2'd1,
        CAS_WAIT_GAP = 2'd2,
        CAS_CMD      = 2'd3
    } cas_state_t;

    cas_state_t r_state;
    cas_state_t w_next;

    // One-entry pending buffer
    logic       r_buf_valid;
    logic [2:0] r_buf_type;
    logic       r_buf_trcd;

    logic [7:0] r_act_cnt;
    logic [7:0] r_gap_cnt;
    logic       r_prev_valid;   // at least one CAS since reset
    logic [2:0] r_cas_req;
    logic       r_ovf;

    // Two data-phase timers
    logic [1:0] r_tv;
    logic [7:0] r_tcnt [2];
    logic [1:0] r_trd;
    logic       r_rd_start;
    logic       r_wr_start;

    logic       w_consume;
    logic       w_busy;
    logic       w_acc_act;
    logic       w_acc_hit;
    logic       w_accept;
    logic       w_drop;
    logic       w_pend_valid;
    logic [2:0] w_pend_type;
    logic       w_pend_trcd;
    logic [7:0] w_pend_cnt;
    logic       w_pend_rd;
    logic       w_pend_wr;
    logic       w_trcd_ok;
    logic [7:0] w_gap_m1;
    logic       w_gap_ok;
    logic       w_needs_slot;
    logic       w_launch_ok;
    logic       w_launch;
    logic [1:0] w_ld;
    logic       w_rd_fire;
    logic       w_wr_fire;

    // ------------------------------------------------------------------
    // Buffer admission. The entry leaving in CAS_CMD counts as free, so a
    // pulse in that same cycle is taken without overflow.
    // ------------------------------------------------------------------
    assign w_consume = (r_state == CAS_CMD);
    assign w_busy    = r_buf_valid && !w_consume;
    assign w_acc_act = act_rdy && !w_busy;
    assign w_acc_hit = no_act_rdy && !act_rdy && !w_busy;
    assign w_accept  = w_acc_act || w_acc_hit;
    assign w_drop    = (act_rdy && no_act_rdy) || ((act_rdy || no_act_rdy) && w_busy);

    // The request the FSM works on: the stored entry, or the pulse arriving
    // this cycle when the buffer is empty. Looking at the incoming pulse
    // directly lets a row hit strobe CAS on the very next cycle.
    assign w_pend_valid = r_buf_valid || w_accept;
    assign w_pend_type  = r_buf_valid ? r_buf_type : act_rw;
    assign w_pend_trcd  = r_buf_valid ? r_buf_trcd : w_acc_act;
    assign w_pend_cnt   = r_buf_valid ? r_act_cnt  : 8'd0;
    assign w_pend_rd    = (w_pend_type == c_RD_R);
    assign w_pend_wr    = (w_pend_type == c_WR_R);

    // act_cnt counts the ACTIVATE cycle itself as 0, so reaching tRCD-1
    // here puts the strobe exactly tRCD cycles after the ACTIVATE.
    assign w_trcd_ok = !w_pend_trcd || (w_pend_cnt >= c_TRCD_M1);

    always_comb begin
        w_gap_m1 = c_TCCD_M1;
        if (c_TA_EN && r_prev_valid) begin
            if ((r_cas_req == c_WR_R) && w_pend_rd) begin
                w_gap_m1 = c_WR2RD_M1;
            end else if ((r_cas_req == c_RD_R) && w_pend_wr) begin
                w_gap_m1 = c_RD2WR_M1;
            end
        end
    end

    assign w_gap_ok     = !r_prev_valid || (r_gap_cnt >= w_gap_m1);
    // Only RD/WR open a data phase; any other code strobes CAS alone.
    assign w_needs_slot = w_pend_rd || w_pend_wr;
    assign w_launch_ok  = !w_needs_slot || !(r_tv[0] && r_tv[1]);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            CAS_IDLE, CAS_WAIT_ACT, CAS_WAIT_GAP: begin
                if (!w_pend_valid) begin
                    w_next = CAS_IDLE;
                end else if (!w_trcd_ok) begin
                    w_next = CAS_WAIT_ACT;
                end else if (w_gap_ok && w_launch_ok) begin
                    w_next = CAS_CMD;
                end else begin
                    w_next = CAS_WAIT_GAP;
                end
            end
            CAS_CMD: w_next = CAS_IDLE;
            default: w_next = CAS_IDLE;
        endcase
    end

    assign w_launch = (w_next == CAS_CMD);
    assign w_ld[0]  = w_launch && w_needs_slot && !r_tv[0];
    assign w_ld[1]  = w_launch && w_needs_slot && r_tv[0] && !r_tv[1];

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CAS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Buffer, counters and CAS bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_valid  <= 1'b0;
            r_buf_type   <= 3'd0;
            r_buf_trcd   <= 1'b0;
            r_act_cnt    <= 8'd0;
            r_gap_cnt    <= 8'd0;
            r_prev_valid <= 1'b0;
            r_cas_req    <= 3'd0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf_valid <= 1'b1;
                r_buf_type  <= act_rw;
                r_buf_trcd  <= w_acc_act;
            end else if (w_consume) begin
                r_buf_valid <= 1'b0;
            end

            if (w_accept) begin
                r_act_cnt <= 8'd1;
            end else if (r_buf_valid && (r_act_cnt != 8'hFF)) begin
                r_act_cnt <= r_act_cnt + 8'd1;
            end

            if (w_launch) begin
                r_gap_cnt    <= 8'd0;
                r_prev_valid <= 1'b1;
                r_cas_req    <= w_pend_type;
            end else if (r_gap_cnt != 8'hFF) begin
                r_gap_cnt <= r_gap_cnt + 8'd1;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data-phase timers. A timer stays valid for one cycle after it fires
    // so cas_idle covers the data-start strobe cycle itself.
    // ------------------------------------------------------------------
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_tv       <= 2'b00;
            r_trd      <= 2'b00;
            r_tcnt[0]  <= 8'd0;
            r_tcnt[1]  <= 8'd0;
            r_rd_start <= 1'b0;
            r_wr_start <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_ld[i]) begin
                    r_tv[i]   <= 1'b1;
                    r_trd[i]  <= w_pend_rd;
                    r_tcnt[i] <= w_pend_rd ? c_CL : c_CWL;
                end else if (r_tv[i]) begin
                    if (r_tcnt[i] == 8'd0) begin
                        r_tv[i] <= 1'b0;
                    end else begin
                        r_tcnt[i] <= r_tcnt[i] - 8'd1;
                    end
                end
            end
            r_rd_start <= w_rd_fire;
            r_wr_start <= w_wr_fire;
        end
    end

    always_comb begin
        w_rd_fire = 1'b0;
        w_wr_fire = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (r_tv[i] && (r_tcnt[i] == 8'd1)) begin
                if (r_trd[i]) begin
                    w_rd_fire = 1'b1;
                end else begin
                    w_wr_fire = 1'b1;
                end
            end
        end
    end

    assign cas_rdy       = (r_state == CAS_CMD);
    assign cas_req       = r_cas_req;
    assign cas_idle      = (r_state == CAS_IDLE) && !r_buf_valid && (r_tv == 2'b00);
    assign rd_data_start = r_rd_start;
    assign wr_data_start = r_wr_start;
    assign cas_ovf       = r_ovf;

endmodule
`default_nettype wire
